cnt_mod_prog: RTL
=================

Name: cnt_mod_prog

Overview:
Programmable-modulus up/down counter with run control and registered output. It succeeds the fixed mod-K counter used for timing and sequencing in the power-managed clock domain. It adds the following over that counter:
- runtime modulus register
- count direction
- synchronous preload
- free-run and one-shot modes, controlled by a three-state FSM
- Busy/Done status

A single Tc pulse per terminal step lets instances be cascaded.

Parameters:
W, 5, counter/modulus/value width in bits
MOD_DEF, 31, modulus register value after reset (terminal count, range 0..2^W-1)
PRESCALE, 4, Cnt-qualified cycles per count step when CNT_PRESCALE_EN is defined (>=2)

Ports:
Clk  input  1  clock, rising edge
Rst  input  1  asynchronous, active-high reset
Pwr_off  input  1  asynchronous, active-high power-off clear
Cnt  input  1  count enable, qualified per cycle
Dir  input  1  1 = count up, 0 = count down
Start  input  1  begin or restart counting (pulse)
Stop  input  1  abort to IDLE (pulse)
Load  input  1  synchronous preload of counter
Load_val  input  W  preload value
Cfg_we  input  1  write Mod_val into modulus register
Mod_val  input  W  terminal count value M
Mode  input  1  0 = free-run, 1 = one-shot; sampled on Start
Tc  output  1  one-cycle pulse on each terminal step
Vout  output  W  registered copy of counter
Busy  output  1  FSM in RUN
Done  output  1  FSM in DONE

Behaviour:
- Reset: Rst or Pwr_off high (async, level) clears:
  - counter = 0, mod_reg = MOD_DEF
  - FSM = IDLE, Tc = 0, Vout = 0, Busy = 0, Done = 0, mode_reg = 0, prescaler = 0
- While Pwr_off is high, all inputs are ignored.
- FSM states:
  - IDLE -> RUN on Start.
  - RUN -> IDLE on Stop.
  - RUN -> DONE on a terminal step when mode_reg = 1.
  - DONE -> RUN on Start; DONE -> IDLE on Stop.
  - Start and Stop in the same cycle: Stop wins.
  - Start while already in RUN re-samples Mode and stays in RUN.
- Count step: occurs only in RUN with Cnt = 1 (and the prescaler terminal, if compiled in).
  - Up: if counter >= mod_reg, counter <= 0 and this is a terminal step; else counter + 1.
  - Down: if counter == 0, counter <= mod_reg and this is a terminal step; else counter - 1.
  - The >= compare makes a counter left above a newly reduced modulus wrap on its next up-step.
  - Down-count from above the modulus decrements normally.
- Tc: registered, high for exactly the one cycle after a terminal step (aligned with the wrapped counter value). Never held, never high in IDLE or DONE.
- One-shot: the terminal step wraps the counter and moves the FSM to DONE in the same edge. Counter then frozen; Done = 1 until Start or Stop.
- Load (any state, not Pwr_off): counter <= Load_val. Load has priority over a count step in the same cycle; that cycle produces no Tc. Load with Start: value loaded and FSM enters RUN on the same edge.
- Cfg_we: mod_reg <= Mod_val next edge; takes effect for compares from the following cycle. M = 0 gives a Tc on every up-step.
- Start does not modify the counter; use Load to preset.
- Vout: counter value delayed by 1 clock (Vout(t+1) = counter(t)). Busy and Done are decoded directly from registered FSM state.
- Arithmetic is modulo 2^W, with no carry out other than Tc.

Optional Feature:
- CNT_PRESCALE_EN defined: a prescaler counter of width clog2(PRESCALE) advances on RUN & Cnt. A count step occurs only when the prescaler equals PRESCALE-1, and the prescaler then wraps to 0. The prescaler is cleared by reset, Start, Load, and when leaving RUN.
- Not defined: no prescaler logic; every RUN & Cnt cycle is a count step.

Test Plan:
- Reset: assert Rst mid-count at counter = 7 -> same cycle counter/Vout/Tc/Busy = 0; mod_reg = 31.
- Free-run up: Start with Mode = 0, Dir = 1, Cnt = 1, Cfg_we Mod_val = 4 -> Vout sequence 0,1,2,3,4,0,1… lagging 1 clock; Tc pulses once per 5 steps.
- One-shot down: Load_val = 3, Start with Mode = 1, Dir = 0 -> counter 3,2,1,0,then wraps to M; Done = 1, Busy = 0, Tc single pulse; further Cnt ignored; Start -> Busy again.
- Modulus shrink: free-run up, counter = 20, Cfg_we Mod_val = 9 -> next step counter = 0 with Tc = 1.
- Collisions: Load_val = 5 on the same cycle as a terminal step -> counter = 5, no Tc. Start+Stop together -> IDLE. Cnt = 1 with Stop -> IDLE, counter held.
- Pwr_off pulse during RUN -> all outputs 0 immediately; after release, Start is required to count. With CNT_PRESCALE_EN and PRESCALE = 4, Tc period = 4·(M+1) cycles.

Source files
------------

// File: rtl/cnt_mod_prog.sv
`default_nettype none
// ============================================================================
// Module   : cnt_mod_prog
// Brief    : Programmable-modulus up/down counter with run control, one-shot
//            and free-run modes, a registered counter copy, and a single-cycle
//            terminal pulse for cascading.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   Clk       in   clock, rising edge
//   Rst       in   asynchronous active-high reset
//   Pwr_off   in   asynchronous active-high power-off clear (inputs ignored)
//   Cnt       in   count enable, qualified per cycle
//   Dir       in   1 = count up, 0 = count down
//   Start     in   begin/restart counting; samples Mode
//   Stop      in   abort to IDLE (wins over Start)
//   Load      in   synchronous preload of counter from Load_val
//   Load_val  in   [W] preload value
//   Cfg_we    in   write Mod_val into the modulus register
//   Mod_val   in   [W] terminal count value M
//   Mode      in   0 = free-run, 1 = one-shot
//   Tc        out  one-cycle pulse after each terminal step
//   Vout      out  [W] counter value delayed by one clock
//   Busy      out  FSM in RUN
//   Done      out  FSM in DONE
// ----------------------------------------------------------------------------
// Build option
//   CNT_PRESCALE_EN : when defined, a count step happens only once every
//                     PRESCALE qualified (RUN & Cnt) cycles.
// ============================================================================
module cnt_mod_prog #(
  parameter int W        = 5,
  parameter int MOD_DEF  = 31,
  parameter int PRESCALE = 4
) (
  input  logic         Clk,
  input  logic         Rst,
  input  logic         Pwr_off,
  input  logic         Cnt,
  input  logic         Dir,
  input  logic         Start,
  input  logic         Stop,
  input  logic         Load,
  input  logic [W-1:0] Load_val,
  input  logic         Cfg_we,
  input  logic [W-1:0] Mod_val,
  input  logic         Mode,
  output logic         Tc,
  output logic [W-1:0] Vout,
  output logic         Busy,
  output logic         Done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t         r_state;
  logic           r_mode;
  logic [W-1:0]   r_cnt;
  logic [W-1:0]   r_mod;
  logic [W-1:0]   r_vout;
  logic           r_tc;

  logic           w_tick;
  logic           w_step;
  logic           w_term;
  logic           w_done_hit;
  logic [W-1:0]   w_cnt_step;

  // Terminal test depends on direction. The up compare is >= so a counter
  // stranded above a freshly lowered modulus wraps on its next up-step.
  assign w_term = Dir ? (r_cnt >= r_mod) : (r_cnt == '0);

  // Stop and Load both suppress the count step in their cycle: Stop holds the
  // counter, Load overrides it (and therefore no Tc is produced).
  assign w_step = (r_state == S_RUN) && Cnt && !Stop && !Load && w_tick;

  // One-shot completion: terminal step while armed in one-shot mode.
  assign w_done_hit = w_step && w_term && r_mode;

  assign w_cnt_step = Dir ? (w_term ? '0    : r_cnt + 1'b1)
                          : (w_term ? r_mod : r_cnt - 1'b1);

`ifdef CNT_PRESCALE_EN
  localparam int              c_PS_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [c_PS_W-1:0] c_PS_LAST = c_PS_W'(PRESCALE - 1);

  logic [c_PS_W-1:0] r_ps;
  logic              w_ps_clr;

  assign w_tick = (r_ps == c_PS_LAST);

  // Cleared whenever the next state will not be RUN, and on every Start or
  // Load so a (re)started count always gets a full first period.
  assign w_ps_clr = Load || Start || Stop || (r_state != S_RUN) || w_done_hit;

  always_ff @(posedge Clk or posedge Rst or posedge Pwr_off) begin
    if (Rst || Pwr_off) begin
      r_ps <= '0;
    end else if (w_ps_clr) begin
      r_ps <= '0;
    end else if (Cnt) begin
      r_ps <= w_tick ? '0 : r_ps + 1'b1;
    end
  end
`else
  assign w_tick = 1'b1;
`endif

  // Control FSM, counter datapath and registered outputs.
  always_ff @(posedge Clk or posedge Rst or posedge Pwr_off) begin
    if (Rst || Pwr_off) begin
      r_state <= S_IDLE;
      r_mode  <= 1'b0;
      r_cnt   <= '0;
      r_mod   <= W'(MOD_DEF);
      r_vout  <= '0;
      r_tc    <= 1'b0;
    end else begin
      r_vout <= r_cnt;
      r_tc   <= w_step && w_term;

      if (Cfg_we) begin
        r_mod <= Mod_val;
      end

      if (Load) begin
        r_cnt <= Load_val;
      end else if (w_step) begin
        r_cnt <= w_cnt_step;
      end

      // Stop beats Start; Start beats one-shot completion (restart wins).
      if (Stop) begin
        r_state <= S_IDLE;
      end else if (Start) begin
        r_state <= S_RUN;
        r_mode  <= Mode;
      end else if (w_done_hit) begin
        r_state <= S_DONE;
      end
    end
  end

  assign Tc   = r_tc;
  assign Vout = r_vout;
  assign Busy = (r_state == S_RUN);
  assign Done = (r_state == S_DONE);

endmodule
`default_nettype wire
